// File: rtl/sum_window_accumulator_pkg.sv
// Shared definitions for the sum-window accumulator and its neighbouring adder stage.
package sum_window_accumulator_pkg;

    localparam int SUM_DATA_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } swa_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/sum_window_result_reg.sv
// Output record register: loads a closed window, holds it until the consumer
// takes it, and numbers records with a wrapping sequence counter.
module sum_window_result_reg #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 10,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [ACC_W-1:0]  total_i,
    input  logic [DATA_W-1:0] mean_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic              partial_i,
    input  logic              out_ready_i,
    output logic              out_valid_o,
    output logic [ACC_W-1:0]  out_total_o,
    output logic [DATA_W-1:0] out_mean_o,
    output logic [CNT_W-1:0]  out_count_o,
    output logic              out_partial_o,
    output logic [7:0]        out_seq_o
);

    logic              valid_q,   valid_d;
    logic [ACC_W-1:0]  total_q,   total_d;
    logic [DATA_W-1:0] mean_q,    mean_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic              partial_q, partial_d;
    logic [7:0]        seq_q,     seq_d;

    // load and pop never coincide: loads happen only while the record is empty
    always_comb begin
        valid_d   = valid_q;
        total_d   = total_q;
        mean_d    = mean_q;
        count_d   = count_q;
        partial_d = partial_q;
        seq_d     = seq_q;
        if (load_i) begin
            valid_d   = 1'b1;
            total_d   = total_i;
            mean_d    = mean_i;
            count_d   = count_i;
            partial_d = partial_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
            seq_d   = seq_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            total_q   <= '0;
            mean_q    <= '0;
            count_q   <= '0;
            partial_q <= 1'b0;
            seq_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            total_q   <= total_d;
            mean_q    <= mean_d;
            count_q   <= count_d;
            partial_q <= partial_d;
            seq_q     <= seq_d;
        end
    end

    assign out_valid_o   = valid_q;
    assign out_total_o   = total_q;
    assign out_mean_o    = mean_q;
    assign out_count_o   = count_q;
    assign out_partial_o = partial_q;
    assign out_seq_o     = seq_q;

endmodule

// File: rtl/sum_window_accumulator.sv
// Accumulates adder-stage sums over a fixed window (or a flushed partial one)
// and presents one total/mean/count record per window.
module sum_window_accumulator
    import sum_window_accumulator_pkg::*;
#(
    parameter int DATA_W = SUM_DATA_W,
    parameter int WINDOW = 4,
    localparam int LOG2_WIN = clog2(WINDOW),
    localparam int ACC_W    = DATA_W + LOG2_WIN
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ACC_W-1:0]    out_total,
    output logic [DATA_W-1:0]   out_mean,
    output logic [LOG2_WIN:0]   out_count,
    output logic                out_partial,
    output logic [7:0]          out_seq
);

    localparam logic [LOG2_WIN:0] WIN_CNT = WINDOW[LOG2_WIN:0];

    swa_state_e        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d, acc_n;
    logic [LOG2_WIN:0] cnt_q, cnt_d, cnt_n;
    logic              accept, close, pop, partial_n;
    logic [DATA_W-1:0] mean_n;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    // Window contents as they stand once this cycle's sample (if any) is in
    assign acc_n = accept ? acc_q + {{LOG2_WIN{1'b0}}, in_data} : acc_q;
    assign cnt_n = accept ? cnt_q + 1'b1 : cnt_q;

    // An empty window ignores flush since cnt_n stays zero
    assign close     = (state_q == ACCUM) && ((cnt_n == WIN_CNT) || (flush && (cnt_n != '0)));
    assign partial_n = (cnt_n != WIN_CNT);
    assign mean_n    = partial_n ? '0 : acc_n[ACC_W-1:LOG2_WIN];

    always_ff @(posedge clk) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM:   if (close) state_d = HOLD;
            HOLD:    if (pop)   state_d = ACCUM;
            default: state_d = ACCUM;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ACCUM) && !rst;
    end

    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (state_q == ACCUM) begin
            acc_d = acc_n;
            cnt_d = cnt_n;
        end else if (pop) begin
            acc_d = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    sum_window_result_reg #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .CNT_W  (LOG2_WIN + 1)
    ) u_result (
        .clk           (clk),
        .rst           (rst),
        .load_i        (close),
        .total_i       (acc_n),
        .mean_i        (mean_n),
        .count_i       (cnt_n),
        .partial_i     (partial_n),
        .out_ready_i   (out_ready),
        .out_valid_o   (out_valid),
        .out_total_o   (out_total),
        .out_mean_o    (out_mean),
        .out_count_o   (out_count),
        .out_partial_o (out_partial),
        .out_seq_o     (out_seq)
    );

endmodule
